readout_rx_seq: RTL and testbench

//  Next-PC sequencer for the readout RX microcode. It sits directly upstream of the RX PC register.
//  - Consumes the decoded instruction at the current PC.
//  - Drives update_pc/next_PC into the PC register.
//  - Handles sequential advance, jumps, nested hardware loops, trigger waits and halt.
//  - Issues one PC decision per cycle, gated by a downstream stall.

---
 rtl/readout_rx_pkg.sv | 22 ++
 rtl/readout_rx_loop_stack.sv | 69 ++++++
 rtl/readout_rx_seq.sv | 178 +++++++++++++++++
 tb/tb_readout_rx_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/readout_rx_pkg.sv
// rtl/readout_rx_pkg.sv - shared opcodes, state encoding and stack entry sizing for the readout RX sequencer
package readout_rx_pkg;

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_LOOP = 3'd2;
  localparam logic [2:0] OP_ENDL = 3'd3;
  localparam logic [2:0] OP_HALT = 3'd4;
  localparam logic [2:0] OP_WAIT = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // A stack entry packs {return address, remaining iterations}
  function automatic int stack_entry_w(input int pc_w, input int cnt_w);
    return pc_w + cnt_w;
  endfunction

endpackage

// File: rtl/readout_rx_loop_stack.sv
// rtl/readout_rx_loop_stack.sv - LIFO of {addr, count} hardware loop frames with push, pop and top decrement
import readout_rx_pkg::*;

module readout_rx_loop_stack #(
  parameter int AW    = 11,
  parameter int CW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic          dec_top,
  input  logic [AW-1:0] push_addr,
  input  logic [CW-1:0] push_count,
  output logic [AW-1:0] top_addr,
  output logic [CW-1:0] top_count,
  output logic          empty,
  output logic          full
);

  localparam int EW = stack_entry_w(AW, CW);
  localparam int PW = $clog2(DEPTH + 1);

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [EW-1:0] top_entry;

  assign empty     = (ptr_q == '0);
  assign full      = (ptr_q == PW'(DEPTH));
  assign top_addr  = top_entry[EW-1:CW];
  assign top_count = top_entry[CW-1:0];

  // ptr_q counts occupied entries, so the top frame lives at ptr_q-1
  always_comb begin
    top_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr_q == PW'(i + 1)) top_entry = mem_q[i];
    end
  end

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ptr_q == PW'(i)) mem_d[i] = {push_addr, push_count};
      end
      ptr_d = ptr_q + PW'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PW'(1);
    end else if (dec_top && !empty && (top_count != '0)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ptr_q == PW'(i + 1)) mem_d[i] = {top_addr, top_count - CW'(1)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
    mem_q <= mem_d;
  end

endmodule

// File: rtl/readout_rx_seq.sv
// rtl/readout_rx_seq.sv - next-PC sequencer for the readout RX microcode (SEQ/JMP/LOOP/ENDL/HALT/WAIT)
// Optional PC bounds checking against PC_MAX is enabled by defining READOUT_RX_SEQ_BOUNDS_EN.
import readout_rx_pkg::*;

module readout_rx_seq #(
  parameter int PC_WIDTH   = 11,
  parameter int CNT_WIDTH  = 10,
  parameter int LOOP_DEPTH = 4,
  parameter int START_PC   = 0,
  parameter int PC_MAX     = 2047
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  PC,
  input  logic                 instr_valid,
  input  logic [2:0]           instr_op,
  input  logic [PC_WIDTH-1:0]  instr_target,
  input  logic [CNT_WIDTH-1:0] instr_count,
  input  logic                 ext_trig,
  input  logic                 stall,
  output logic                 update_pc,
  output logic [PC_WIDTH-1:0]  next_PC,
  output logic                 running,
  output logic                 done,
  output logic                 loop_err,
  output logic                 pc_err
);

  state_t state_q, state_d;
  logic   loop_err_q, loop_err_d;
  logic   pc_err_q, pc_err_d;

  logic                 go;
  logic [PC_WIDTH-1:0]  pc_inc;
  logic [PC_WIDTH-1:0]  cand_pc;
  logic [CNT_WIDTH-1:0] push_count;
  logic                 want_upd, loop_fault, halt_req, restart, bounds_fault;
  logic                 push_req, pop_req, dec_req;
  logic [PC_WIDTH-1:0]  top_addr;
  logic [CNT_WIDTH-1:0] top_count;
  logic                 stk_empty, stk_full;

  assign go     = instr_valid & ~stall;
  assign pc_inc = PC + PC_WIDTH'(1);
  // A count of 0 still runs the body once, so it stores the same frame as a count of 1
  assign push_count = (instr_count == '0) ? '0 : instr_count - CNT_WIDTH'(1);

  readout_rx_loop_stack #(
    .AW    (PC_WIDTH),
    .CW    (CNT_WIDTH),
    .DEPTH (LOOP_DEPTH)
  ) u_stack (
    .clk        (clk),
    .rst        (rst),
    .clr        (restart),
    .push       (push_req & ~bounds_fault),
    .pop        (pop_req & ~bounds_fault),
    .dec_top    (dec_req & ~bounds_fault),
    .push_addr  (pc_inc),
    .push_count (push_count),
    .top_addr   (top_addr),
    .top_count  (top_count),
    .empty      (stk_empty),
    .full       (stk_full)
  );

  // Decision for this cycle: candidate PC and the side effects it implies
  always_comb begin
    cand_pc    = '0;
    want_upd   = 1'b0;
    loop_fault = 1'b0;
    halt_req   = 1'b0;
    restart    = 1'b0;
    push_req   = 1'b0;
    pop_req    = 1'b0;
    dec_req    = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          restart  = 1'b1;
          want_upd = 1'b1;
          cand_pc  = PC_WIDTH'(START_PC);
        end
      end
      RUN: begin
        if (go) begin
          case (instr_op)
            OP_JMP: begin
              cand_pc  = instr_target;
              want_upd = 1'b1;
            end
            OP_LOOP: begin
              if (stk_full) begin
                loop_fault = 1'b1;
              end else begin
                push_req = 1'b1;
                cand_pc  = pc_inc;
                want_upd = 1'b1;
              end
            end
            OP_ENDL: begin
              if (stk_empty) begin
                loop_fault = 1'b1;
              end else if (top_count != '0) begin
                dec_req  = 1'b1;
                cand_pc  = top_addr;
                want_upd = 1'b1;
              end else begin
                pop_req  = 1'b1;
                cand_pc  = pc_inc;
                want_upd = 1'b1;
              end
            end
            OP_HALT: halt_req = 1'b1;
            OP_WAIT: begin
              cand_pc  = pc_inc;
              want_upd = ext_trig;
            end
            default: begin
              cand_pc  = pc_inc;
              want_upd = 1'b1;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

`ifdef READOUT_RX_SEQ_BOUNDS_EN
  assign bounds_fault = want_upd && (int'(cand_pc) > PC_MAX);
`else
  assign bounds_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      loop_err_q <= 1'b0;
      pc_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      loop_err_q <= loop_err_d;
      pc_err_q   <= pc_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    loop_err_d = loop_err_q;
    pc_err_d   = pc_err_q;
    if (restart) begin
      state_d    = RUN;
      loop_err_d = 1'b0;
      pc_err_d   = 1'b0;
    end
    if (halt_req) state_d = HALT;
    if (loop_fault) begin
      loop_err_d = 1'b1;
      state_d    = HALT;
    end
    if (bounds_fault) begin
      pc_err_d = 1'b1;
      state_d  = HALT;
    end
  end

  always_comb begin
    update_pc = want_upd & ~bounds_fault;
    next_PC   = cand_pc;
    running   = (state_q == RUN);
    done      = (state_q == HALT);
    loop_err  = loop_err_q;
    pc_err    = pc_err_q;
  end

endmodule

// File: tb/tb_readout_rx_seq.sv
// tb/tb_readout_rx_seq.sv - directed self-checking bench for readout_rx_seq
module tb_readout_rx_seq;
  import readout_rx_pkg::*;

`ifdef READOUT_RX_SEQ_BOUNDS_EN
  localparam int TB_PC_MAX = 100;
  localparam int JT        = 'h050;
`else
  localparam int TB_PC_MAX = 2047;
  localparam int JT        = 'h1F0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, instr_valid, ext_trig, stall;
  logic [10:0] PC, instr_target, next_PC;
  logic [2:0]  instr_op;
  logic [9:0]  instr_count;
  logic        update_pc, running, done, loop_err, pc_err;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  readout_rx_seq #(
    .PC_WIDTH(11), .CNT_WIDTH(10), .LOOP_DEPTH(4), .START_PC(0), .PC_MAX(TB_PC_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .PC(PC), .instr_valid(instr_valid),
    .instr_op(instr_op), .instr_target(instr_target), .instr_count(instr_count),
    .ext_trig(ext_trig), .stall(stall), .update_pc(update_pc), .next_PC(next_PC),
    .running(running), .done(done), .loop_err(loop_err), .pc_err(pc_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_upd(input string tag, input logic exp_u, input int exp_pc);
    chk({tag, "_upd"}, 32'(update_pc), 32'(exp_u));
    if (exp_u) chk({tag, "_npc"}, 32'(next_PC), 32'(exp_pc));
  endtask

  // Apply one cycle of inputs at the falling edge; outputs are sampled 1ns later
  task automatic step(input logic [2:0] op, input int pc, input int tgt = 0, input int cnt = 0,
                      input logic trig = 1'b0, input logic stl = 1'b0, input logic st = 1'b0,
                      input logic v = 1'b1);
    @(negedge clk);
    instr_op     = op;
    PC           = 11'(pc);
    instr_target = 11'(tgt);
    instr_count  = 10'(cnt);
    ext_trig     = trig;
    stall        = stl;
    start        = st;
    instr_valid  = v;
    #1;
  endtask

  task automatic restart(input string tag);
    step(OP_SEQ, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_upd(tag, 1'b1, 0);
    step(OP_SEQ, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_running"}, 32'(running), 1);
  endtask

  int lp_pc [7] = '{10, 11, 12, 11, 12, 11, 12};
  int lp_nx [7] = '{11, 12, 11, 12, 11, 12, 13};

  initial begin
    rst = 1'b1; start = 1'b0; instr_valid = 1'b0; instr_op = OP_SEQ; PC = '0;
    instr_target = '0; instr_count = '0; ext_trig = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_upd", 32'(update_pc), 0);
    chk("rst_npc", 32'(next_PC), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_loop_err", 32'(loop_err), 0);
    chk("rst_pc_err", 32'(pc_err), 0);
    @(negedge clk);
    rst = 1'b0;

    step(OP_SEQ, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_upd("idle_nostart", 1'b0, 0);
    step(OP_SEQ, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_upd("start", 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      step(OP_SEQ, i);
      chk_upd("seq", 1'b1, i + 1);
      chk("seq_running", 32'(running), 1);
    end

    step(OP_JMP, 5, JT, 0, 1'b0, 1'b1);
    chk_upd("jmp_stall0", 1'b0, 0);
    step(OP_JMP, 5, JT, 0, 1'b0, 1'b1);
    chk_upd("jmp_stall1", 1'b0, 0);
    step(OP_JMP, 5, JT);
    chk_upd("jmp", 1'b1, JT);
    step(OP_SEQ, 6, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_upd("invalid", 1'b0, 0);
    step(OP_SEQ, 7, 0, 0, 1'b0, 1'b0, 1'b1);
    chk_upd("start_in_run", 1'b1, 8);

    for (int i = 0; i < 7; i++) begin
      step((lp_pc[i] == 10) ? OP_LOOP : (lp_pc[i] == 12) ? OP_ENDL : OP_SEQ, lp_pc[i], 0, 3);
      chk_upd("loop3", 1'b1, lp_nx[i]);
    end
    step(OP_ENDL, 13);
    chk_upd("endl_empty", 1'b0, 0);
    step(OP_SEQ, 14);
    chk_upd("halted_seq", 1'b0, 0);
    chk("endl_empty_err", 32'(loop_err), 1);
    chk("endl_empty_done", 32'(done), 1);
    chk("endl_empty_running", 32'(running), 0);

    restart("restart1");
    chk("restart1_err_clr", 32'(loop_err), 0);
    step(OP_LOOP, 30, 0, 0);
    chk_upd("loop0", 1'b1, 31);
    step(OP_ENDL, 31);
    chk_upd("loop0_endl", 1'b1, 32);

    for (int i = 0; i < 4; i++) begin
      step(OP_LOOP, 40 + i, 0, 2);
      chk_upd("nest", 1'b1, 41 + i);
    end
    step(OP_LOOP, 44, 0, 2);
    chk_upd("overflow", 1'b0, 0);
    chk("overflow_err_early", 32'(loop_err), 0);
    step(OP_SEQ, 45, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("overflow_err", 32'(loop_err), 1);
    chk("overflow_done", 32'(done), 1);

    restart("restart2");
    chk("restart2_err_clr", 32'(loop_err), 0);
    repeat (5) begin
      step(OP_WAIT, 20);
      chk_upd("wait_lo", 1'b0, 0);
    end
    step(OP_WAIT, 20, 0, 0, 1'b1, 1'b1);
    chk_upd("wait_stall_trig", 1'b0, 0);
    step(OP_WAIT, 20, 0, 0, 1'b1);
    chk_upd("wait_trig", 1'b1, 21);
    step(OP_HALT, 21);
    chk_upd("halt", 1'b0, 0);
    chk("halt_running_same_cycle", 32'(running), 1);
    step(OP_SEQ, 22, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("halt_done", 32'(done), 1);
    chk("halt_running", 32'(running), 0);
    chk("halt_loop_err", 32'(loop_err), 0);

    restart("restart3");
    step(OP_SEQ, 'h7FF);
    chk_upd("wrap", 1'b1, 0);
    step(3'd6, 50);
    chk_upd("undef6", 1'b1, 51);
    step(3'd7, 51);
    chk_upd("undef7", 1'b1, 52);
    chk("pc_err_idle", 32'(pc_err), 0);

    step(OP_LOOP, 60, 0, 5);
    chk_upd("rst_loop_push", 1'b1, 61);
    step(OP_SEQ, 61);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_running", 32'(running), 0);
    chk("midrst_done", 32'(done), 0);
    chk_upd("midrst", 1'b0, 0);
    rst = 1'b0;
    restart("restart4");
    step(OP_ENDL, 0);
    chk_upd("midrst_stack_empty", 1'b0, 0);
    step(OP_SEQ, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_stack_err", 32'(loop_err), 1);

`ifdef READOUT_RX_SEQ_BOUNDS_EN
    restart("restart5");
    step(OP_JMP, 0, 100);
    chk_upd("bounds_ok", 1'b1, 100);
    step(OP_JMP, 100, 101);
    chk_upd("bounds_blk", 1'b0, 0);
    step(OP_SEQ, 100, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bounds_pc_err", 32'(pc_err), 1);
    chk("bounds_done", 32'(done), 1);
    restart("restart6");
    chk("bounds_pc_err_clr", 32'(pc_err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
